// File: rtl/cr_pmp_pkg.sv
// Shared PMP checker definitions: access/privilege encodings, index-width helpers
// and the fault-record layout used by cr_pmp_acc_chk.
package cr_pmp_pkg;

  localparam logic [1:0] ACC_EXEC  = 2'b00;
  localparam logic [1:0] ACC_LOAD  = 2'b01;
  localparam logic [1:0] ACC_STORE = 2'b10;

  localparam logic [1:0] PRIV_M = 2'b11;

  // Widest indices the fault record must hold (16 regions, 4 channels).
  localparam int RIDX_MAX = 4;
  localparam int CIDX_MAX = 2;

  function automatic int ridx_w(input int region_num);
    return (region_num > 1) ? $clog2(region_num) : 1;
  endfunction

  function automatic int cidx_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  typedef struct packed {
    logic [CIDX_MAX-1:0] ch;
    logic [RIDX_MAX-1:0] idx;
    logic                hit;
    logic [1:0]          acc_type;
    logic [1:0]          priv;
  } flt_rec_t;

endpackage

// File: rtl/cr_pmp_acc_chk_prio_sel.sv
// Lowest-set-bit priority encoder over one channel's region-hit vector.
module cr_pmp_prio_sel #(
  parameter int REGION_NUM = 8,
  parameter int RIDX_W     = 3
) (
  input  logic [REGION_NUM-1:0] hit_vec,
  output logic                  hit,
  output logic [RIDX_W-1:0]     idx
);

  assign hit = |hit_vec;

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = REGION_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = i[RIDX_W-1:0];
    end
  end

endmodule

// File: rtl/cr_pmp_acc_chk.sv
// Registered N-channel PMP access checker with sticky first-fault record.
// The fault record is built only when PMP_FAULT_CAPTURE_EN is defined.
module cr_pmp_acc_chk
  import cr_pmp_pkg::*;
#(
  parameter  int REGION_NUM = 8,
  parameter  int CH_NUM     = 2,
  localparam int RIDX_W     = ridx_w(REGION_NUM),
  localparam int CIDX_W     = cidx_w(CH_NUM)
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst,
  input  logic [REGION_NUM-1:0]        regs_comp_lock,
  input  logic [REGION_NUM-1:0]        regs_comp_read,
  input  logic [REGION_NUM-1:0]        regs_comp_write,
  input  logic [REGION_NUM-1:0]        regs_comp_excut,
  input  logic [CH_NUM-1:0]            chk_req_vld,
  output logic [CH_NUM-1:0]            chk_req_rdy,
  input  logic [CH_NUM*REGION_NUM-1:0] chk_req_hit,
  input  logic [CH_NUM*2-1:0]          chk_req_type,
  input  logic [CH_NUM*2-1:0]          chk_req_priv,
  output logic [CH_NUM-1:0]            chk_rsp_vld,
  input  logic [CH_NUM-1:0]            chk_rsp_rdy,
  output logic [CH_NUM-1:0]            chk_rsp_deny,
  output logic [CH_NUM-1:0]            chk_rsp_hit,
  output logic [CH_NUM*RIDX_W-1:0]     chk_rsp_idx,
  input  logic                         flt_clr,
  output logic                         flt_vld,
  output logic                         flt_ovf,
  output logic [CIDX_W-1:0]            flt_ch,
  output logic [RIDX_W-1:0]            flt_idx,
  output logic                         flt_hit,
  output logic [1:0]                   flt_type,
  output logic [1:0]                   flt_priv
);

  logic [CH_NUM-1:0]        req_fire;
  logic [CH_NUM-1:0]        deny_c;
  logic [CH_NUM-1:0]        hit_c;
  logic [RIDX_W-1:0]        idx_c [CH_NUM];

  logic [CH_NUM-1:0]        rsp_vld;
  logic [CH_NUM-1:0]        rsp_deny;
  logic [CH_NUM-1:0]        rsp_hit;
  logic [CH_NUM*RIDX_W-1:0] rsp_idx;

  assign chk_req_rdy = ~rsp_vld | chk_rsp_rdy;
  assign req_fire    = chk_req_vld & chk_req_rdy;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [1:0] acc_type;
    logic [1:0] priv;
    logic       perm;
    logic       deny;

    assign acc_type = chk_req_type[c*2 +: 2];
    assign priv     = chk_req_priv[c*2 +: 2];

    cr_pmp_prio_sel #(
      .REGION_NUM (REGION_NUM),
      .RIDX_W     (RIDX_W)
    ) u_prio_sel (
      .hit_vec (chk_req_hit[c*REGION_NUM +: REGION_NUM]),
      .hit     (hit_c[c]),
      .idx     (idx_c[c])
    );

    always_comb begin
      case (acc_type)
        ACC_EXEC: perm = regs_comp_excut[idx_c[c]];
        ACC_LOAD: perm = regs_comp_read[idx_c[c]];
        default:  perm = regs_comp_write[idx_c[c]];
      endcase
      // Unmatched accesses fall back to the privilege default.
      if (!hit_c[c])
        deny = (priv != PRIV_M);
      else if (priv == PRIV_M)
        deny = regs_comp_lock[idx_c[c]] & ~perm;
      else
        deny = ~perm;
    end

    assign deny_c[c] = deny;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rsp_vld  <= '0;
      rsp_deny <= '0;
      rsp_hit  <= '0;
      rsp_idx  <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (req_fire[c]) begin
          rsp_vld[c]                   <= 1'b1;
          rsp_deny[c]                  <= deny_c[c];
          rsp_hit[c]                   <= hit_c[c];
          rsp_idx[c*RIDX_W +: RIDX_W]  <= idx_c[c];
        end else if (chk_rsp_rdy[c]) begin
          rsp_vld[c] <= 1'b0;
        end
      end
    end
  end

  assign chk_rsp_vld  = rsp_vld;
  assign chk_rsp_deny = rsp_deny;
  assign chk_rsp_hit  = rsp_hit;
  assign chk_rsp_idx  = rsp_idx;

`ifdef PMP_FAULT_CAPTURE_EN
  flt_rec_t          rec;
  flt_rec_t          rec_nxt;
  logic              rec_vld;
  logic              rec_ovf;
  logic [CH_NUM-1:0] deny_fire;

  assign deny_fire = req_fire & deny_c;

  // Lowest-index denying channel wins the capture.
  always_comb begin
    rec_nxt = '0;
    for (int c = CH_NUM - 1; c >= 0; c--) begin
      if (deny_fire[c]) begin
        rec_nxt.ch       = CIDX_MAX'(c);
        rec_nxt.idx      = RIDX_MAX'(idx_c[c]);
        rec_nxt.hit      = hit_c[c];
        rec_nxt.acc_type = chk_req_type[c*2 +: 2];
        rec_nxt.priv     = chk_req_priv[c*2 +: 2];
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rec     <= '0;
      rec_vld <= 1'b0;
      rec_ovf <= 1'b0;
    end else if (|deny_fire) begin
      if (!rec_vld || flt_clr) begin
        rec     <= rec_nxt;
        rec_vld <= 1'b1;
        rec_ovf <= 1'b0;
      end else begin
        rec_ovf <= 1'b1;
      end
    end else if (flt_clr) begin
      rec_vld <= 1'b0;
      rec_ovf <= 1'b0;
    end
  end

  // Upper index bits of the record are spare for small configurations.
  logic [$bits(flt_rec_t)-1:0] unused_rec;
  assign unused_rec = rec;

  assign flt_vld  = rec_vld;
  assign flt_ovf  = rec_ovf;
  assign flt_ch   = rec.ch[CIDX_W-1:0];
  assign flt_idx  = rec.idx[RIDX_W-1:0];
  assign flt_hit  = rec.hit;
  assign flt_type = rec.acc_type;
  assign flt_priv = rec.priv;
`else
  logic unused_flt_clr;
  assign unused_flt_clr = flt_clr;

  assign flt_vld  = 1'b0;
  assign flt_ovf  = 1'b0;
  assign flt_ch   = '0;
  assign flt_idx  = '0;
  assign flt_hit  = 1'b0;
  assign flt_type = 2'b00;
  assign flt_priv = 2'b00;
`endif

endmodule

// File: doc/cr_pmp_acc_chk.md
# cr_pmp_acc_chk

Parametrised, registered PMP access checker for the PMP unit. It takes per-channel region-hit vectors from the address comparators plus the shared per-region attribute bits, and resolves the matching region by priority. It produces one registered permit/deny response per channel behind a valid/ready handshake, and records the first denied access in a sticky fault record for cp0/debug. It generalises the fixed IFU+LSU, 8-region attribute matcher to N channels, M regions, pipelined operation and fault capture.

## Interface
- REGION_NUM, 8: number of PMP entries, 1..16.
- CH_NUM, 2: number of requesting channels, 1..4; channel 0 has highest fault-capture priority.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are forever_cpuclk and cpurst.
- forever_cpuclk  in  1  core clock.
- cpurst  in  1  synchronous active-high reset.
- regs_comp_lock / regs_comp_read / regs_comp_write / regs_comp_excut  in  REGION_NUM each  per-entry L/R/W/X bits.
- chk_req_vld  in  CH_NUM  request valid per channel.
- chk_req_rdy  out  CH_NUM  request accepted this cycle when vld&rdy.
- chk_req_hit  in  CH_NUM*REGION_NUM  region-hit vector; channel c occupies bits [c*REGION_NUM +: REGION_NUM].
- chk_req_type  in  CH_NUM*2  access type: 00 exec, 01 load, 10 store, 11 store.
- chk_req_priv  in  CH_NUM*2  effective privilege, already MPRV-resolved; 11 machine, any other value user.
- chk_rsp_vld  out  CH_NUM  response valid.
- chk_rsp_rdy  in  CH_NUM  response consumed when vld&rdy.
- chk_rsp_deny  out  CH_NUM  access denied.
- chk_rsp_hit  out  CH_NUM  some region matched.
- chk_rsp_idx  out  CH_NUM*RIDX_W  matched region index, 0 if no hit.
- flt_clr  in  1  clear fault record.
- flt_vld  out  1  fault record holds a fault.
- flt_ovf  out  1  a further deny occurred while flt_vld was set.
- flt_ch  out  CIDX_W  faulting channel.
- flt_idx  out  RIDX_W  faulting region index.
- flt_hit  out  1  faulting access hit a region.
- flt_type  out  2  faulting access type.
- flt_priv  out  2  faulting privilege.

## Operation
- Region select: lowest set bit of the channel's hit vector wins. chk_rsp_hit = |hit.
- No hit: deny = user mode; machine mode is permitted.
- Hit, region r: perm = X[r] for exec, R[r] for load, W[r] for store.
- Hit, machine mode: deny = L[r] & !perm.
- Hit, user mode: deny = !perm.
- Pipeline per channel is one register stage. chk_req_rdy[c] = !rsp_vld[c] | chk_rsp_rdy[c].
- On req fire, deny/hit/idx load into the stage and rsp_vld sets.
- On rsp fire without a new req, rsp_vld clears.
- Response fields hold stable while vld & !rdy.
- Fault capture is evaluated at each edge over the set of channels firing with combinational deny=1.
  - If flt_vld=0, or flt_clr=1 in the same cycle: record the lowest-index such channel; flt_vld=1, flt_ovf=0.
  - If flt_vld=1 and flt_clr=0: record unchanged; flt_ovf=1.
  - Multiple simultaneous denies with flt_vld=0 capture the lowest channel only and leave flt_ovf=0.
  - flt_clr with no new deny: flt_vld=0 and flt_ovf=0; the other fields keep their last value.
- Attribute bits are sampled at req fire. Later attribute changes do not alter a pending response.
- RIDX_W = max(1, clog2(REGION_NUM)). CIDX_W = max(1, clog2(CH_NUM)).

## Timing
- Reset: chk_rsp_vld=0, chk_rsp_deny=0, chk_rsp_hit=0, chk_rsp_idx=0, all flt_* outputs 0.
- chk_req_rdy = all 1 after reset.
- Latency: req fire in cycle N gives chk_rsp_vld in N+1. Full throughput of 1 per cycle per channel while chk_rsp_rdy=1.
- chk_req_rdy is combinational from chk_rsp_rdy; there is no other combinational path from input to output.
- A fault is visible on flt_* in the same cycle its response becomes valid.
- Reset asserted mid-transaction drops pending responses with no completion.

## Configuration
- PMP_FAULT_CAPTURE_EN defined: fault record implemented as above.
- PMP_FAULT_CAPTURE_EN undefined: no fault registers; all flt_* outputs tied 0; flt_clr ignored. Checker behaviour is unchanged.

## Structure
- Shared package cr_pmp_pkg holds:
  - access-type encodings ACC_EXEC=2'b00, ACC_LOAD=2'b01, ACC_STORE=2'b10;
  - PRIV_M=2'b11;
  - the RIDX_W/CIDX_W width functions;
  - the fault-record struct.
- Sub-module cr_pmp_prio_sel: REGION_NUM-wide lowest-set-bit priority encoder giving hit and idx. It is instantiated once per channel.

## Test plan
- Reset, then ch0 exec, priv=00, hit=0 → cycle 1: rsp_vld=1, deny=1, hit=0; flt_vld=1, flt_ch=0, flt_hit=0.
- ch1 load, priv=11, hit=8'b0001_0100, L[2]=1, R[2]=0 → deny=1, idx=2; the same access with L[2]=0 → deny=0.
- ch0 store, user, hit=8'b1000_0001, W[0]=1, W[7]=0 → deny=0, idx=0 (priority to the lowest region).
- Backpressure: chk_rsp_rdy=0 for 3 cycles after a response → rsp fields stable, chk_req_rdy=0; rdy=1 with a new req → next response loads back-to-back with no bubble.
- Fault record:
  - ch0 and ch1 both deny in the same cycle → flt_ch=0, flt_ovf=0.
  - A further deny next cycle → flt_ovf=1.
  - flt_clr together with a ch1 deny → flt_ch=1, flt_ovf=0.
  - flt_clr alone → flt_vld=0.
- Build with PMP_FAULT_CAPTURE_EN undefined → a denying access gives flt_vld=0 and the response is unchanged.
